usb_tx_encoder: RTL and testbench

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

---
 rtl/usb_tx_pkg.sv | 25 ++
 rtl/usb_tx_nrzi.sv | 38 +++
 rtl/usb_tx_encoder.sv | 151 +++++++++++++++
 tb/tb_usb_tx_encoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared FSM states, stuffing/EOP limits and line-state encodings for the USB transmitter
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0A,
        ST_EOP_SE0B,
        ST_EOP_J
    } tx_state_t;

    localparam int STUFF_LIMIT  = 6;
    localparam int EOP_SE0_BITS = 2;

    // Line states as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic is_eop(tx_state_t s);
        return s inside {ST_EOP_SE0A, ST_EOP_SE0B, ST_EOP_J};
    endfunction

endpackage

// File: rtl/usb_tx_nrzi.sv
// usb_tx_nrzi: NRZI encoder and registered D+/D- drive; a 0 toggles J/K, a 1 holds the line
module usb_tx_nrzi
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic data_bit,
    input  logic bit_en,
    input  logic se0,
    input  logic idle,
    output logic dp,
    output logic dm
);

    logic lvl_j;
    logic next_j;

    assign next_j = lvl_j ^ ~data_bit;

    // Line advances once per bit time; idle forces J and re-arms the NRZI level for the next packet
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lvl_j    <= 1'b1;
            {dp, dm} <= LINE_J;
        end else if (bit_en) begin
            if (idle) begin
                lvl_j    <= 1'b1;
                {dp, dm} <= LINE_J;
            end else if (se0) begin
                {dp, dm} <= LINE_SE0;
            end else begin
                lvl_j    <= next_j;
                {dp, dm} <= next_j ? LINE_J : LINE_K;
            end
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: byte stream to USB full-speed line encoder with bit stuffing, NRZI and EOP generation
module usb_tx_encoder
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bit_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_oe,
    output logic       underrun
);

    tx_state_t  state, state_n;
    logic [7:0] sh, sh_n, hold_data;
    logic [2:0] idx, idx_n, ones, ones_n;
    logic       cur_last, last_n, hold_full, hold_full_n, hold_last;
    logic       accept, consume, send, nxt, oe_n, urun_n;
    logic       data_bit, se0, idle;

    assign accept      = tx_valid && tx_ready;
    assign hold_full_n = accept || (hold_full && !consume);

    // Next-state and line-drive decision; the current bit is sh[idx], ones counts the trailing run of 1s
    always_comb begin
        state_n  = state;
        sh_n     = sh;
        idx_n    = idx;
        ones_n   = ones;
        last_n   = cur_last;
        oe_n     = tx_oe;
        urun_n   = 1'b0;
        consume  = 1'b0;
        send     = 1'b0;
        nxt      = sh[idx + 3'd1];
        data_bit = 1'b1;
        se0      = 1'b0;
        idle     = 1'b0;
        if (bit_en) begin
            case (state)
                ST_IDLE: begin
                    idle    = !hold_full;
                    consume = hold_full;
                end
                ST_DATA, ST_STUFF: begin
                    if (state == ST_DATA && ones == 3'(STUFF_LIMIT)) begin
                        state_n = ST_STUFF;
                        send    = 1'b1;
                        nxt     = 1'b0;
                    end else if (idx != 3'd7) begin
                        state_n = ST_DATA;
                        send    = 1'b1;
                        idx_n   = idx + 3'd1;
                    end else if (cur_last || !hold_full) begin
                        state_n = ST_EOP_SE0A;
                        se0     = 1'b1;
                        ones_n  = 3'd0;
                        urun_n  = !cur_last;
                    end else begin
                        consume = 1'b1;
                    end
                end
                ST_EOP_SE0A: begin
                    state_n = (EOP_SE0_BITS > 1) ? ST_EOP_SE0B : ST_EOP_J;
                    se0     = 1'b1;
                end
                ST_EOP_SE0B: begin
                    state_n = ST_EOP_J;
                    idle    = 1'b1;
                end
                ST_EOP_J: begin
                    state_n = ST_IDLE;
                    idle    = 1'b1;
                    oe_n    = 1'b0;
                end
                default: begin
                    state_n = ST_IDLE;
                    idle    = 1'b1;
                    oe_n    = 1'b0;
                end
            endcase
            if (consume) begin
                state_n = ST_DATA;
                sh_n    = hold_data;
                idx_n   = 3'd0;
                last_n  = hold_last;
                oe_n    = 1'b1;
                send    = 1'b1;
                nxt     = hold_data[0];
            end
            if (send) begin
                data_bit = nxt;
                ones_n   = nxt ? ones + 3'd1 : 3'd0;
            end
        end
    end

    // One-entry holding register between the byte handshake and the bit-time shifter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
            hold_last <= 1'b0;
        end else begin
            hold_full <= hold_full_n;
            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
            end
        end
    end

    // FSM, shifter and registered control outputs; tx_ready is precomputed from next-cycle state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            sh       <= 8'h00;
            idx      <= 3'd0;
            ones     <= 3'd0;
            cur_last <= 1'b0;
            tx_oe    <= 1'b0;
            underrun <= 1'b0;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            idx      <= idx_n;
            ones     <= ones_n;
            cur_last <= last_n;
            tx_oe    <= oe_n;
            underrun <= urun_n;
            tx_ready <= !hold_full_n && !is_eop(state_n);
        end
    end

    usb_tx_nrzi u_nrzi (
        .clk      (clk),
        .n_rst    (n_rst),
        .data_bit (data_bit),
        .bit_en   (bit_en),
        .se0      (se0),
        .idle     (idle),
        .dp       (dp_out),
        .dm       (dm_out)
    );

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: vector table, reset corner cases and random packets checked against a bit-level model
module tb_usb_tx_encoder;
    import usb_tx_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       bit_en = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, dp_out, dm_out, tx_oe, underrun;

    int checks = 0;
    int failures = 0;
    int ur_cycles;
    int acc_cnt;
    logic [7:0] pkt_q[$];
    logic [3:0] rec_q[$];
    logic [3:0] exp_q[$];

    typedef struct {
        int         n;
        logic [7:0] b1;
        bit         last;
        int         per;
        string      dp;
        string      dm;
        int         ur;
    } vec_t;
    vec_t vecs[4];

    usb_tx_encoder dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bit_en   (bit_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .dp_out   (dp_out),
        .dm_out   (dm_out),
        .tx_oe    (tx_oe),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive pkt_q through the handshake and record {dp,dm,oe,underrun} at every bit time of the packet
    task automatic run_pkt(input bit last, input int per);
        int i;
        int cyc;
        bit acc;
        bit started;
        bit done;
        logic [2:0] prev;
        i = 0;
        cyc = 0;
        started = 1'b0;
        done = 1'b0;
        rec_q.delete();
        ur_cycles = 0;
        prev = {dp_out, dm_out, tx_oe};
        while (!done && cyc < 4000) begin
            @(negedge clk);
            bit_en   = (cyc % per) == 0;
            tx_valid = i < pkt_q.size();
            tx_data  = tx_valid ? pkt_q[i] : 8'h00;
            tx_last  = last && (i == pkt_q.size() - 1);
            acc      = tx_valid && tx_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                check("ready_after_accept", 32'(tx_ready), 32'(0));
            end
            if (underrun) ur_cycles++;
            if (bit_en) begin
                if (tx_oe) started = 1'b1;
                if (started) begin
                    rec_q.push_back({dp_out, dm_out, tx_oe, underrun});
                    if (!dp_out && !dm_out) check("ready_in_eop", 32'(tx_ready), 32'(0));
                    if (!tx_oe) done = 1'b1;
                end
            end else begin
                check("hold_between_strobes", 32'({dp_out, dm_out, tx_oe}), 32'(prev));
            end
            prev = {dp_out, dm_out, tx_oe};
            cyc++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        bit_en   = 1'b0;
        acc_cnt  = i;
        check("packet_completed", 32'(done), 32'(1));
    endtask

    // Reference: LSB-first bits, a 0 inserted after every six consecutive 1s, NRZI from J, then SE0,SE0,J,idle
    task automatic build_model(input bit last);
        bit lvl;
        int ones;
        lvl = 1'b1;
        ones = 0;
        exp_q.delete();
        foreach (pkt_q[j]) begin
            for (int k = 0; k < 8; k++) begin
                if (!pkt_q[j][k]) lvl = !lvl;
                exp_q.push_back({lvl, !lvl, 2'b10});
                ones = pkt_q[j][k] ? ones + 1 : 0;
                if (ones == STUFF_LIMIT) begin
                    lvl = !lvl;
                    exp_q.push_back({lvl, !lvl, 2'b10});
                    ones = 0;
                end
            end
        end
        for (int k = 0; k < EOP_SE0_BITS; k++) exp_q.push_back({3'b001, k == 0 && !last});
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b1000);
    endtask

    task automatic exp_from_vec(input vec_t v);
        bit first;
        logic d, m;
        first = 1'b1;
        exp_q.delete();
        for (int k = 0; k < v.dp.len(); k++) begin
            d = v.dp[k] == "1";
            m = v.dm[k] == "1";
            exp_q.push_back({d, m, k < v.dp.len() - 1, v.ur != 0 && !d && !m && first});
            if (!d && !m) first = 1'b0;
        end
    endtask

    task automatic compare(input string tag, input int ur);
        check({tag, "_len"}, 32'(rec_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < rec_q.size() && k < exp_q.size(); k++)
            check($sformatf("%s_bit%0d", tag, k), 32'(rec_q[k]), 32'(exp_q[k]));
        check({tag, "_underrun_clks"}, 32'(ur_cycles), 32'(ur));
        check({tag, "_bytes_accepted"}, 32'(acc_cnt), 32'(pkt_q.size()));
    endtask

    bit last;
    int per;
    int extra;

    initial begin
        vecs[0] = '{2, 8'hA5, 1'b1, 1, "01010100011011000011", "10101011100100110000", 0};
        vecs[1] = '{2, 8'hFF, 1'b1, 3, "010101000000011110011", "101010111111100000000", 0};
        vecs[2] = '{1, 8'h00, 1'b0, 2, "010101000011", "101010110000", 1};
        vecs[3] = '{2, 8'h3F, 1'b1, 4, "010101000000011010011", "101010111111100100000", 0};

        #12;
        check("reset_state", 32'({dp_out, dm_out, tx_oe, tx_ready, underrun}), 32'(5'b10010));
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'({dp_out, dm_out, tx_oe, tx_ready}), 32'(4'b1001));

        foreach (vecs[v]) begin
            pkt_q = '{8'h80};
            if (vecs[v].n == 2) pkt_q.push_back(vecs[v].b1);
            run_pkt(vecs[v].last, vecs[v].per);
            exp_from_vec(vecs[v]);
            compare($sformatf("vec%0d", v), vecs[v].ur);
        end

        pkt_q = '{8'h80, 8'h5A, 8'hC3};
        build_model(1'b1);
        run_pkt(1'b1, 4);
        compare("stream3", 0);

        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h80;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            bit_en = 1'b1;
        end
        @(negedge clk);
        bit_en   = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        check("pre_reset_active", 32'({tx_oe, tx_ready}), 32'(2'b10));
        #2 n_rst = 1'b0;
        #1;
        check("mid_packet_reset", 32'({dp_out, dm_out, tx_oe, tx_ready, underrun}), 32'(5'b10010));
        @(negedge clk);
        n_rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            bit_en = 1'b1;
        end
        @(negedge clk);
        bit_en = 1'b0;
        check("no_restart_after_reset", 32'({dp_out, dm_out, tx_oe}), 32'(3'b100));
        pkt_q = '{8'h80, 8'hA5};
        build_model(1'b1);
        run_pkt(1'b1, 2);
        compare("after_reset", 0);

        for (int r = 0; r < 12; r++) begin
            last  = $urandom_range(0, 3) != 0;
            per   = $urandom_range(1, 5);
            extra = $urandom_range(0, 3);
            pkt_q = '{8'h80};
            for (int b = 0; b < extra; b++)
                pkt_q.push_back($urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom));
            build_model(last);
            run_pkt(last, per);
            compare($sformatf("rand%0d", r), last ? 0 : 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
